// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: merges debounced button pulses and UART command bytes into
// one serialized command stream. Each command is routed to the watch or the
// stopwatch control unit depending on sw_mode, and UART commands may be
// acknowledged by echoing a byte into the TX FIFO.
module cmd_dispatcher #(
    parameter logic ACK_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_clear,
    input  logic       btn_move,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_run,
    input  logic       rx_empty,
    input  logic [7:0] rx_data,
    output logic       rx_rd,
    input  logic       tx_full,
    output logic       tx_wr,
    output logic [7:0] tx_wdata,
    output logic       sw_mode,
    output logic       w_clear,
    output logic       w_move,
    output logic       w_inc,
    output logic       w_dec,
    output logic       s_run,
    output logic       s_clear,
    output logic       busy
);

    // Command kinds, one-hot. Bit index doubles as button priority:
    // the lowest set index wins.
    localparam int K_MODE  = 0;
    localparam int K_CLEAR = 1;
    localparam int K_MOVE  = 2;
    localparam int K_INC   = 3;
    localparam int K_DEC   = 4;
    localparam int K_RUN   = 5;

    // Positions of the control-unit pulses in the pulse register.
    localparam int P_WCLR = 0;
    localparam int P_WMOV = 1;
    localparam int P_WINC = 2;
    localparam int P_WDEC = 3;
    localparam int P_SRUN = 4;
    localparam int P_SCLR = 5;

    localparam logic [7:0] NAK_BYTE = 8'h3F;  // "?"

    typedef enum logic [2:0] {
        IDLE,
        POP,
        DECODE,
        DISPATCH,
        ACK
    } state_t;

    state_t     state;
    logic [5:0] pending;    // sticky button presses awaiting dispatch
    logic [5:0] btn_vec;    // this cycle's presses, in kind order
    logic [5:0] btn_sel;    // highest-priority pending button, one-hot
    logic [5:0] pend_clr;   // pending bit consumed this cycle
    logic [5:0] rx_kind;    // decoded kind of the byte on rx_data
    logic       rx_accept;  // byte is legal in the current mode
    logic [5:0] pulse;      // registered CU pulses
    logic [7:0] cmd;        // latched UART byte, echoed in the ack
    logic       is_uart;    // command in DISPATCH came from the UART
    logic       accepted;   // UART command was accepted
    logic       toggle;     // command in DISPATCH is a mode toggle

    // Maps a command kind to the CU pulse it produces in the given mode.
    // Mode-illegal commands and the mode toggle itself yield no pulse.
    function automatic logic [5:0] route(input logic [5:0] kind, input logic mode);
        logic [5:0] p;
        p         = '0;
        p[P_WCLR] = kind[K_CLEAR] &  mode;
        p[P_SCLR] = kind[K_CLEAR] & ~mode;
        p[P_WMOV] = kind[K_MOVE]  &  mode;
        p[P_WINC] = kind[K_INC]   &  mode;
        p[P_WDEC] = kind[K_DEC]   &  mode;
        p[P_SRUN] = kind[K_RUN]   & ~mode;
        return p;
    endfunction

    assign btn_vec  = {btn_run, btn_dec, btn_inc, btn_move, btn_clear, btn_mode};
    // Isolate the lowest set bit: that is the highest-priority button.
    assign btn_sel  = pending & (~pending + 6'd1);
    // A pending bit is consumed only when IDLE picks it for dispatch.
    assign pend_clr = (state == IDLE) ? btn_sel : 6'd0;

    assign w_clear = pulse[P_WCLR];
    assign w_move  = pulse[P_WMOV];
    assign w_inc   = pulse[P_WINC];
    assign w_dec   = pulse[P_WDEC];
    assign s_run   = pulse[P_SRUN];
    assign s_clear = pulse[P_SCLR];

    // Case-sensitive ASCII decode of the RX byte into a command kind.
    always_comb begin
        rx_kind = '0;
        case (rx_data)
            8'h4D:   rx_kind[K_MODE]  = 1'b1;  // "M"
            8'h43:   rx_kind[K_CLEAR] = 1'b1;  // "C"
            8'h52:   rx_kind[K_MOVE]  = 1'b1;  // "R"
            8'h55:   rx_kind[K_INC]   = 1'b1;  // "U"
            8'h44:   rx_kind[K_DEC]   = 1'b1;  // "D"
            8'h47:   rx_kind[K_RUN]   = 1'b1;  // "G"
            default: rx_kind = '0;
        endcase
    end

    assign rx_accept = rx_kind[K_MODE] | (|route(rx_kind, sw_mode));

    // Sticky press capture; a press coinciding with its own clear re-sets the bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pending <= '0;
        else
            pending <= (pending & ~pend_clr) | btn_vec;
    end

    // Command sequencer: arbitration, RX pop, decode, dispatch and ack echo.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pulse    <= '0;
            rx_rd    <= 1'b0;
            tx_wr    <= 1'b0;
            tx_wdata <= 8'h00;
            sw_mode  <= 1'b0;
            busy     <= 1'b0;
            cmd      <= 8'h00;
            is_uart  <= 1'b0;
            accepted <= 1'b0;
            toggle   <= 1'b0;
        end else begin
            pulse <= '0;
            rx_rd <= 1'b0;
            tx_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (|pending) begin
                        // Buttons always beat a waiting RX byte.
                        state   <= DISPATCH;
                        busy    <= 1'b1;
                        is_uart <= 1'b0;
                        toggle  <= btn_sel[K_MODE];
                        pulse   <= route(btn_sel, sw_mode);
                    end else if (!rx_empty) begin
                        state <= POP;
                        busy  <= 1'b1;
                        rx_rd <= 1'b1;
                    end
                end
                POP: begin
                    // rx_data becomes valid during DECODE.
                    state <= DECODE;
                end
                DECODE: begin
                    state    <= DISPATCH;
                    cmd      <= rx_data;
                    is_uart  <= 1'b1;
                    toggle   <= rx_kind[K_MODE];
                    accepted <= rx_accept;
                    pulse    <= route(rx_kind, sw_mode);
                end
                DISPATCH: begin
                    // Pulse is on the wire this cycle; mode flips at its end.
                    if (toggle)
                        sw_mode <= ~sw_mode;
                    if (is_uart && ACK_EN) begin
                        state    <= ACK;
                        tx_wdata <= accepted ? cmd : NAK_BYTE;
                        // Only this block writes the TX FIFO, so a not-full
                        // flag seen now still holds on the write cycle.
                        tx_wr    <= ~tx_full;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                ACK: begin
                    if (tx_wr) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!tx_full) begin
                        tx_wr <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Scoreboard bench for cmd_dispatcher: stimulus pushes expected CU pulses and
// ack bytes from a command-level model; a monitor pops and compares them.
module tb_cmd_dispatcher;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       btn_mode  = 1'b0;
    logic       btn_clear = 1'b0;
    logic       btn_move  = 1'b0;
    logic       btn_inc   = 1'b0;
    logic       btn_dec   = 1'b0;
    logic       btn_run   = 1'b0;
    logic       rx_empty  = 1'b1;
    logic [7:0] rx_data   = 8'h00;
    logic       tx_full   = 1'b0;
    logic       rx_rd, tx_wr, sw_mode, busy;
    logic       w_clear, w_move, w_inc, w_dec, s_run, s_clear;
    logic [7:0] tx_wdata;

    cmd_dispatcher #(.ACK_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_clear(btn_clear), .btn_move(btn_move),
        .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_run(btn_run),
        .rx_empty(rx_empty), .rx_data(rx_data), .rx_rd(rx_rd),
        .tx_full(tx_full), .tx_wr(tx_wr), .tx_wdata(tx_wdata),
        .sw_mode(sw_mode),
        .w_clear(w_clear), .w_move(w_move), .w_inc(w_inc), .w_dec(w_dec),
        .s_run(s_run), .s_clear(s_clear), .busy(busy)
    );

    always #5 clk = ~clk;

    // Expected-pulse encoding used by the scoreboard.
    localparam logic [5:0] W_CLEAR = 6'b000001;
    localparam logic [5:0] W_MOVE  = 6'b000010;
    localparam logic [5:0] W_INC   = 6'b000100;
    localparam logic [5:0] W_DEC   = 6'b001000;
    localparam logic [5:0] S_RUN   = 6'b010000;
    localparam logic [5:0] S_CLEAR = 6'b100000;
    // Button masks {run,dec,inc,move,clear,mode}.
    localparam logic [5:0] B_CLEAR = 6'b000010;
    localparam logic [5:0] B_INC   = 6'b001000;

    int tests = 0, fails = 0, cyc = 0;
    int n_rd = 0, last_rd = -1, last_pulse = -1, last_tx = -1;
    logic       model_mode = 1'b0;
    logic       full_q = 1'b0;
    logic [5:0] prev_pv = 6'd0;
    logic [5:0] exp_pulse[$];
    logic [7:0] exp_ack[$];
    logic [7:0] rxq[$];
    logic [7:0] tbl[10] = '{8'h4D, 8'h43, 8'h52, 8'h55, 8'h44, 8'h47, 8'h6D, 8'h3F, 8'h00, 8'h75};

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        full_q <= tx_full;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---- command-level reference model ----
    // kind: 0 mode, 1 clear, 2 move, 3 inc, 4 dec, 5 run, -1 unknown
    function automatic int byte_kind(input logic [7:0] b);
        case (b)
            8'h4D:   return 0;
            8'h43:   return 1;
            8'h52:   return 2;
            8'h55:   return 3;
            8'h44:   return 4;
            8'h47:   return 5;
            default: return -1;
        endcase
    endfunction

    function automatic logic [5:0] model_pulse(input int kind, input logic mode);
        case (kind)
            1:       return mode ? W_CLEAR : S_CLEAR;
            2:       return mode ? W_MOVE  : 6'd0;
            3:       return mode ? W_INC   : 6'd0;
            4:       return mode ? W_DEC   : 6'd0;
            5:       return mode ? 6'd0    : S_RUN;
            default: return 6'd0;
        endcase
    endfunction

    task automatic expect_cmd(input int kind, input bit uart, input logic [7:0] b);
        logic [5:0] p;
        p = model_pulse(kind, model_mode);
        if (p != 6'd0) exp_pulse.push_back(p);
        if (uart) exp_ack.push_back((kind == 0 || p != 6'd0) ? b : 8'h3F);
        if (kind == 0) model_mode = ~model_mode;
    endtask

    // ---- stimulus helpers ----
    task automatic send_uart(input logic [7:0] b, output int k);
        expect_cmd(byte_kind(b), 1'b1, b);
        @(negedge clk);
        rxq.push_back(b);
        rx_empty = 1'b0;
        k = cyc;
    endtask

    task automatic press(input logic [5:0] mask, input bit model, output int k);
        if (model)
            for (int i = 0; i < 6; i++)
                if (mask[i]) expect_cmd(i, 1'b0, 8'h00);
        @(negedge clk);
        {btn_run, btn_dec, btn_inc, btn_move, btn_clear, btn_mode} = mask;
        k = cyc;
        @(negedge clk);
        {btn_run, btn_dec, btn_inc, btn_move, btn_clear, btn_mode} = 6'd0;
    endtask

    task automatic wait_idle(input string name);
        int quiet, n;
        quiet = 0;
        n     = 0;
        repeat (3) @(negedge clk);
        while (quiet < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (!busy && rx_empty) quiet++;
            else quiet = 0;
        end
        check({name, "_idle_timeout"}, 32'(quiet), 32'd3);
    endtask

    // RX FIFO model: pop on rx_rd, data valid the following cycle.
    always @(negedge clk) begin
        if (!rst && rx_rd) begin
            n_rd++;
            last_rd = cyc;
            if (rxq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rx_pop: pop with RX FIFO empty at cycle %0d", cyc);
            end else begin
                rx_data = rxq.pop_front();
            end
            rx_empty = (rxq.size() == 0);
        end
    end

    // Monitor: compare every CU pulse and TX write against the scoreboard.
    always @(negedge clk) begin
        logic [5:0] pv;
        pv = {s_clear, s_run, w_dec, w_inc, w_move, w_clear};
        if (!rst) begin
            if (pv != 6'd0) begin
                last_pulse = cyc;
                check("pulse_onehot", 32'($onehot(pv)), 32'd1);
                check("pulse_separated", 32'(prev_pv), 32'd0);
                if (exp_pulse.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL pulse: got %b, required no pulse (cycle %0d)", pv, cyc);
                end else begin
                    check("pulse", 32'(pv), 32'(exp_pulse.pop_front()));
                end
            end
            if (tx_wr) begin
                last_tx = cyc;
                check("tx_wr_while_full", 32'(full_q), 32'd0);
                if (exp_ack.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL ack: got %h, required no write (cycle %0d)", tx_wdata, cyc);
                end else begin
                    check("ack_byte", 32'(tx_wdata), 32'(exp_ack.pop_front()));
                end
            end
        end
        prev_pv = rst ? 6'd0 : pv;
    end

    initial begin
        int k, j, rd0, r;
        logic [7:0] b;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs",
              32'({rx_rd, tx_wr, tx_wdata, sw_mode, w_clear, w_move, w_inc, w_dec, s_run, s_clear, busy}),
              32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Watch mode, then "U": rd at +1, w_inc at +3, ack at +4
        send_uart(8'h4D, k);
        wait_idle("m1");
        check("sw_mode_M", 32'(sw_mode), 32'(model_mode));
        send_uart(8'h55, k);
        wait_idle("u1");
        check("U_rd_cycle", 32'(last_rd), 32'(k + 1));
        check("U_pulse_cycle", 32'(last_pulse), 32'(k + 3));
        check("U_ack_cycle", 32'(last_tx), 32'(k + 4));

        // Stopwatch mode: "R" rejected, "G" runs
        send_uart(8'h4D, k);
        wait_idle("m2");
        check("sw_mode_M2", 32'(sw_mode), 32'(model_mode));
        send_uart(8'h52, k);
        wait_idle("r");
        send_uart(8'h47, k);
        wait_idle("g");

        // Button latency in watch mode
        send_uart(8'h4D, k);
        wait_idle("m3");
        press(B_INC, 1'b1, k);
        wait_idle("binc");
        check("btn_pulse_cycle", 32'(last_pulse), 32'(k + 2));

        // Clear + inc together, then "D": w_clear, w_inc, w_dec in order
        press(B_CLEAR | B_INC, 1'b1, k);
        send_uart(8'h44, j);
        wait_idle("prio");

        // Repeated presses while busy collapse into one command
        send_uart(8'h55, k);
        press(B_INC, 1'b1, j);
        press(B_INC, 1'b0, j);
        wait_idle("collapse");

        // TX full stall during ACK
        @(negedge clk);
        tx_full = 1'b1;
        send_uart(8'h43, k);
        repeat (4) @(negedge clk);
        send_uart(8'h55, j);
        rd0 = n_rd;
        repeat (10) begin
            @(negedge clk);
            check("stall_tx_wr", 32'(tx_wr), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
        end
        check("stall_no_pop", 32'(n_rd), 32'(rd0));
        tx_full = 1'b0;
        @(negedge clk);
        check("ack_after_stall", 32'(tx_wr), 32'd1);
        wait_idle("stall");

        // "M" then "C" from stopwatch mode
        send_uart(8'h4D, k);
        wait_idle("m4");
        check("sw_mode_m4", 32'(sw_mode), 32'd0);
        send_uart(8'h4D, k);
        wait_idle("m5");
        check("sw_mode_m5", 32'(sw_mode), 32'd1);
        send_uart(8'h43, k);
        wait_idle("c");

        // Reset during DECODE discards the popped byte
        @(negedge clk);
        rxq.push_back(8'h43);
        rx_empty = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_outputs",
              32'({rx_rd, tx_wr, tx_wdata, sw_mode, w_clear, w_move, w_inc, w_dec, s_run, s_clear, busy}),
              32'd0);
        check("rst_mid_byte_popped", 32'(rxq.size()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_mode = 1'b0;
        repeat (4) @(negedge clk);
        send_uart(8'h47, k);
        wait_idle("after_rst");

        // Randomized command mix
        repeat (40) begin
            r = $urandom_range(0, 3);
            if (r < 2) begin
                b = tbl[$urandom_range(0, 9)];
                send_uart(b, k);
            end else if (r == 2) begin
                b = 8'($urandom_range(0, 255));
                send_uart(b, k);
            end else begin
                press(6'($urandom_range(1, 63)), 1'b1, k);
            end
            wait_idle("rand");
            check("rand_sw_mode", 32'(sw_mode), 32'(model_mode));
        end

        check("pulses_outstanding", 32'(exp_pulse.size()), 32'd0);
        check("acks_outstanding", 32'(exp_ack.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
